// File: rtl/node_mac_seq.sv
// Fully-connected neuron: sum(A[i]*Wt[i]) + bias, round half up, saturate, optional ReLU.
// Latency: vector accepted at edge 0, out_valid after edge N_IN+1; one vector per N_IN+3 cycles.
// Backpressure: in_ready only in IDLE; result held stable until out_ready; busy writes dropped.
module node_mac_seq #(
   parameter int N_IN = 10,
   parameter int W    = 16,
   parameter int FRAC = 8,
   parameter int RELU = 1,
   localparam int AW    = $clog2(N_IN+1),
   localparam int ACC_W = 2*W + $clog2(N_IN+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN*W-1:0] in_data,
   input  logic              wt_we,
   input  logic [AW-1:0]     wt_addr,
   input  logic [W-1:0]      wt_data,
   output logic              wt_drop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

   localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC-1);
   localparam logic signed [ACC_W:0] SMAX = {{(ACC_W-W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SMIN = {{(ACC_W-W+2){1'b1}}, {(W-1){1'b0}}};

   state_t                   state, state_nxt;
   logic signed [W-1:0]      wt  [N_IN];
   logic signed [W-1:0]      act [N_IN];
   logic signed [W-1:0]      bias;
   logic signed [ACC_W-1:0]  acc;
   logic        [AW-1:0]     idx;

   logic signed [W-1:0]      a_sel, w_sel, bias_eff, r_sat;
   logic signed [2*W-1:0]    prod;
   logic signed [ACC_W-1:0]  prod_ext, acc_init;
   logic signed [ACC_W:0]    rsum, rsh;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = MAC;
         MAC:     if (idx == AW'(N_IN-1)) state_nxt = RND;
         RND:     state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      a_sel = '0;
      w_sel = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (idx == AW'(i)) begin
            a_sel = act[i];
            w_sel = wt[i];
         end
      end
   end

   assign prod     = (2*W)'(a_sel) * (2*W)'(w_sel);
   assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

   // A bias write coinciding with acceptance must already seed the accumulator.
   assign bias_eff = (wt_we && wt_addr == AW'(N_IN)) ? wt_data : bias;
   assign acc_init = {{(ACC_W-W-FRAC){bias_eff[W-1]}}, bias_eff, {FRAC{1'b0}}};

   always_comb begin
      rsum = {acc[ACC_W-1], acc} + HALF;
      rsh  = rsum >>> FRAC;
      if (rsh > SMAX)      r_sat = {1'b0, {(W-1){1'b1}}};
      else if (rsh < SMIN) r_sat = {1'b1, {(W-1){1'b0}}};
      else                 r_sat = rsh[W-1:0];
      if (RELU != 0 && r_sat[W-1]) r_sat = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_IN; i++) begin
            wt[i]  <= '0;
            act[i] <= '0;
         end
         bias     <= '0;
         acc      <= '0;
         idx      <= '0;
         out_data <= '0;
         wt_drop  <= 1'b0;
      end else begin
         wt_drop <= 1'b0;
         if (wt_we) begin
            if (state == IDLE) begin
               for (int i = 0; i < N_IN; i++)
                  if (wt_addr == AW'(i)) wt[i] <= wt_data;
               if (wt_addr == AW'(N_IN)) bias <= wt_data;
            end else if (wt_addr <= AW'(N_IN)) begin
               wt_drop <= 1'b1;
            end
         end
         case (state)
            IDLE: if (in_valid) begin
               for (int i = 0; i < N_IN; i++) act[i] <= in_data[i*W +: W];
               acc <= acc_init;
               idx <= '0;
            end
            MAC: begin
               acc <= acc + prod_ext;
               idx <= idx + AW'(1);
            end
            RND:     out_data <= r_sat;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_node_mac_seq.sv
// Directed bench for node_mac_seq; a ReLU and a pass-through instance share all inputs.
module tb_node_mac_seq;
   localparam int N_IN = 10;
   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int AW   = $clog2(N_IN+1);

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, wt_we, out_ready;
   logic [N_IN*W-1:0] in_data;
   logic [AW-1:0]     wt_addr;
   logic [W-1:0]      wt_data;
   logic              in_ready1, wt_drop1, out_valid1, busy1;
   logic              in_ready0, wt_drop0, out_valid0, busy0;
   logic [W-1:0]      out_data1, out_data0;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   node_mac_seq #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .RELU(1)) u_dut_relu (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .wt_drop(wt_drop1),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1));

   node_mac_seq #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .RELU(0)) u_dut_lin (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .wt_drop(wt_drop0),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0));

   function automatic logic [N_IN*W-1:0] fill(input logic [W-1:0] v);
      logic [N_IN*W-1:0] r;
      for (int i = 0; i < N_IN; i++) r[i*W +: W] = v;
      return r;
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic write_wt(input int a, input logic [W-1:0] d);
      wt_we = 1'b1; wt_addr = AW'(a); wt_data = d;
      @(posedge clk); #1;
      wt_we = 1'b0;
   endtask

   task automatic load_wts(input logic [W-1:0] wv, input logic [W-1:0] bv);
      for (int i = 0; i < N_IN; i++) write_wt(i, wv);
      write_wt(N_IN, bv);
   endtask

   task automatic run_vector(input logic [N_IN*W-1:0] vec, input logic we, input int a,
                             input logic [W-1:0] d, output logic [W-1:0] d1,
                             output logic [W-1:0] d0, output int lat);
      in_valid = 1'b1; in_data = vec;
      wt_we = we; wt_addr = AW'(a); wt_data = d;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; wt_we = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid1) break;
      end
      d1 = out_data1; d0 = out_data0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      in_valid = 1'b0; in_data = '0; wt_we = 1'b0; wt_addr = '0; wt_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++; if (in_ready1 !== 1'b1) $display("FAIL rst_in_ready act=%b exp=1", in_ready1); else passes++;
      checks++; if (out_valid1 !== 1'b0) $display("FAIL rst_out_valid act=%b exp=0", out_valid1); else passes++;
      checks++; if (busy1 !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy1); else passes++;
      checks++; if (out_data1 !== 16'h0000) $display("FAIL rst_out_data act=%h exp=0000", out_data1); else passes++;
      checks++; if (wt_drop1 !== 1'b0) $display("FAIL rst_wt_drop act=%b exp=0", wt_drop1); else passes++;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [W-1:0] d1, d0; int lat;
      load_wts(16'h0100, 16'h0000);
      run_vector(fill(16'h0080), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (lat !== 11) $display("FAIL basic_latency act=%0d exp=11", lat); else passes++;
      checks++; if (d1 !== 16'h0500) $display("FAIL basic_relu act=%h exp=0500", d1); else passes++;
      checks++; if (d0 !== 16'h0500) $display("FAIL basic_lin act=%h exp=0500", d0); else passes++;
   endtask

   task automatic test_bias_relu;
      logic [W-1:0] d1, d0; int lat;
      load_wts(16'h0000, 16'hFFD5);
      run_vector(fill(16'h0100), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (lat !== 11) $display("FAIL bias_latency act=%0d exp=11", lat); else passes++;
      checks++; if (d1 !== 16'h0000) $display("FAIL bias_relu act=%h exp=0000", d1); else passes++;
      checks++; if (d0 !== 16'hFFD5) $display("FAIL bias_lin act=%h exp=ffd5", d0); else passes++;
   endtask

   task automatic test_saturation;
      logic [W-1:0] d1, d0; int lat;
      load_wts(16'h7FFF, 16'h0000);
      run_vector(fill(16'h7FFF), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d1 !== 16'h7FFF) $display("FAIL sat_pos_relu act=%h exp=7fff", d1); else passes++;
      checks++; if (d0 !== 16'h7FFF) $display("FAIL sat_pos_lin act=%h exp=7fff", d0); else passes++;
      load_wts(16'h8000, 16'h0000);
      run_vector(fill(16'h7FFF), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d1 !== 16'h0000) $display("FAIL sat_neg_relu act=%h exp=0000", d1); else passes++;
      checks++; if (d0 !== 16'h8000) $display("FAIL sat_neg_lin act=%h exp=8000", d0); else passes++;
   endtask

   task automatic test_rounding;
      logic [W-1:0] d1, d0; int lat;
      logic [N_IN*W-1:0] v;
      v = fill(16'h0000);
      v[0 +: W] = 16'h0001;
      load_wts(16'h0000, 16'h0000);
      write_wt(0, 16'h0080);
      run_vector(v, 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'h0001) $display("FAIL rnd_half act=%h exp=0001", d0); else passes++;
      write_wt(0, 16'h007F);
      run_vector(v, 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'h0000) $display("FAIL rnd_below_half act=%h exp=0000", d0); else passes++;
      write_wt(0, 16'hFF80);
      run_vector(v, 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'h0000) $display("FAIL rnd_neg_half act=%h exp=0000", d0); else passes++;
      write_wt(0, 16'hFF7F);
      run_vector(v, 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'hFFFF) $display("FAIL rnd_neg_lin act=%h exp=ffff", d0); else passes++;
      checks++; if (d1 !== 16'h0000) $display("FAIL rnd_neg_relu act=%h exp=0000", d1); else passes++;
   endtask

   task automatic test_wt_write;
      logic [W-1:0] d1, d0; int lat;
      load_wts(16'h0100, 16'h0000);
      write_wt(11, 16'h7FFF);
      checks++; if (wt_drop1 !== 1'b0) $display("FAIL wr_oob_drop act=%b exp=0", wt_drop1); else passes++;
      run_vector(fill(16'h0080), 1'b1, N_IN, 16'h0100, d1, d0, lat);
      checks++; if (d0 !== 16'h0600) $display("FAIL wr_bias_same_cycle act=%h exp=0600", d0); else passes++;
      run_vector(fill(16'h0080), 1'b1, 0, 16'h0300, d1, d0, lat);
      checks++; if (d0 !== 16'h0700) $display("FAIL wr_wt_same_cycle act=%h exp=0700", d0); else passes++;
   endtask

   task automatic test_backpressure;
      logic [W-1:0] d1, d0; int lat; int k;
      load_wts(16'h0100, 16'h0000);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = fill(16'h0080);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      write_wt(0, 16'h7FFF);
      checks++; if (wt_drop1 !== 1'b1) $display("FAIL bp_drop_pulse act=%b exp=1", wt_drop1); else passes++;
      checks++; if (busy1 !== 1'b1) $display("FAIL bp_busy act=%b exp=1", busy1); else passes++;
      checks++; if (in_ready1 !== 1'b0) $display("FAIL bp_in_ready_mac act=%b exp=0", in_ready1); else passes++;
      @(posedge clk); #1;
      checks++; if (wt_drop1 !== 1'b0) $display("FAIL bp_drop_end act=%b exp=0", wt_drop1); else passes++;
      k = 0;
      while (!out_valid1 && k < 40) begin @(posedge clk); #1; k++; end
      checks++; if (out_valid1 !== 1'b1) $display("FAIL bp_out_valid_timeout act=%b exp=1", out_valid1); else passes++;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0); in_data = fill(16'h7FFF);
         @(posedge clk); #1;
         checks++; if (out_valid1 !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d act=%b exp=1", i, out_valid1); else passes++;
         checks++; if (out_data1 !== 16'h0500) $display("FAIL bp_hold_data cyc=%0d act=%h exp=0500", i, out_data1); else passes++;
         checks++; if (in_ready1 !== 1'b0) $display("FAIL bp_in_ready cyc=%0d act=%b exp=0", i, in_ready1); else passes++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b0) $display("FAIL bp_release_valid act=%b exp=0", out_valid1); else passes++;
      checks++; if (in_ready1 !== 1'b1) $display("FAIL bp_release_ready act=%b exp=1", in_ready1); else passes++;
      @(posedge clk); #1;
      checks++; if (busy1 !== 1'b0) $display("FAIL bp_no_ghost_op act=%b exp=0", busy1); else passes++;
      run_vector(fill(16'h0080), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'h0500) $display("FAIL bp_weight_kept act=%h exp=0500", d0); else passes++;
   endtask

   task automatic test_back_to_back;
      int acc_cyc [3]; int n; int cyc; int outs;
      load_wts(16'h0100, 16'h0000);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = fill(16'h0080);
      n = 0; cyc = 0; outs = 0;
      while (n < 3 && cyc < 80) begin
         if (in_ready1) begin acc_cyc[n] = cyc; n++; end
         if (out_valid1 && out_data0 === 16'h0500) outs++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (n !== 3) $display("FAIL b2b_accepts act=%0d exp=3", n); else passes++;
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 13) $display("FAIL b2b_period1 act=%0d exp=13", acc_cyc[1] - acc_cyc[0]); else passes++;
      checks++; if (acc_cyc[2] - acc_cyc[1] !== 13) $display("FAIL b2b_period2 act=%0d exp=13", acc_cyc[2] - acc_cyc[1]); else passes++;
      checks++; if (outs !== 2) $display("FAIL b2b_results act=%0d exp=2", outs); else passes++;
      cyc = 0;
      while (busy1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_reset_midop;
      logic [W-1:0] d1, d0; int lat;
      load_wts(16'h0100, 16'h0000);
      in_valid = 1'b1; in_data = fill(16'h0080);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b0) $display("FAIL mid_rst_valid act=%b exp=0", out_valid1); else passes++;
      checks++; if (busy1 !== 1'b0) $display("FAIL mid_rst_busy act=%b exp=0", busy1); else passes++;
      checks++; if (in_ready1 !== 1'b1) $display("FAIL mid_rst_ready act=%b exp=1", in_ready1); else passes++;
      @(posedge clk); #1;
      reset = 1'b1;
      run_vector(fill(16'h0080), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d0 !== 16'h0000) $display("FAIL mid_rst_wts_zero act=%h exp=0000", d0); else passes++;
      load_wts(16'h0100, 16'h0000);
      run_vector(fill(16'h0080), 1'b0, 0, '0, d1, d0, lat);
      checks++; if (d1 !== 16'h0500) $display("FAIL mid_rst_rerun act=%h exp=0500", d1); else passes++;
      checks++; if (lat !== 11) $display("FAIL mid_rst_latency act=%0d exp=11", lat); else passes++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_bias_relu;
      test_saturation;
      test_rounding;
      test_wt_write;
      test_backpressure;
      test_back_to_back;
      test_reset_midop;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
